multicycle_control: RTL
=======================

# multicycle_control

Finite-state controller that sequences the shared-memory, multi-cycle MIPS datapath: one ALU, one unified instruction/data memory, and the IR, A, B, ALUOut and MDR registers. It executes the same eight-opcode subset as the single-cycle control unit (R-type, ADDI, ORI, LUI, ANDI, BEQ, LW, SW) and keeps that unit's ALUOp encoding, so the existing ALU control is reused unchanged. Every memory access uses a ready handshake, so wait-state memories are supported.

## Interface
- `ALUOP_W`, default 3: ALUOp width. 000 ADDI/add, 001 ORI, 010 LUI, 011 ANDI, 100 BEQ/sub, 101 LW/add, 110 SW/add, 111 R-type (funct decode).
- `clk` in 1: the single clock.
- `reset` in 1: reset is synchronous and active-high.
- `op` in 6: opcode, IR[31:26]. Valid from DECODE onward.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write`, `pc_write_cond`, `ir_write`, `reg_write` out 1 each: register write strobes. The datapath ANDs `pc_write_cond` with ALU zero.
- `mem_read`, `mem_write` out 1 each: memory request, held until `mem_ready`.
- `i_or_d` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `reg_dst` out 1: destination select, 0 = rt, 1 = rd.
- `mem_to_reg` out 1: write-back data select, 0 = ALUOut, 1 = MDR.
- `alu_src_a` out 1: ALU A select, 0 = PC, 1 = A.
- `alu_src_b` out 2: ALU B select, 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = immediate << 2.
- `pc_source` out 1: next-PC select, 0 = ALU result, 1 = ALUOut.
- `alu_op` out ALUOP_W: ALUOp code.
- `instr_done` out 1: one-cycle pulse in the last cycle of each instruction.
- `illegal_op` out 1: one-cycle pulse in DECODE when the opcode is unsupported.
- `state` out 4: current state, for debug.

## Operation
- States (4-bit encoding):
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5
  - EXEC_R=6, R_WB=7, BRANCH=8, EXEC_I=9, I_WB=10
  - Codes 11–15 go to FETCH on the next cycle.
- FETCH:
  - Outputs: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=000, `pc_source`=0.
  - `pc_write` and `ir_write` equal `mem_ready` (Mealy-gated).
  - Stay while `mem_ready`=0; go to DECODE when it is 1.
- DECODE:
  - Outputs: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=000. This precomputes the branch target into ALUOut.
  - Next state by opcode: R→EXEC_R; ADDI/ORI/LUI/ANDI→EXEC_I; BEQ→BRANCH; LW/SW→MEM_ADDR.
  - Any other opcode: `illegal_op`=1, `instr_done`=1, next state FETCH (executes as a NOP).
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=111.
- R_WB: `reg_dst`=1, `mem_to_reg`=0, `reg_write`=1, `instr_done`=1; then FETCH.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10, `alu_op` = the opcode's code (000/001/010/011).
- I_WB: `reg_dst`=0, `mem_to_reg`=0, `reg_write`=1, `alu_op` held from EXEC_I, `instr_done`=1; then FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=100, `pc_write_cond`=1, `pc_source`=1, `instr_done`=1; then FETCH.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op` = 101 for LW, 110 for SW. Next state MEM_RD for LW, MEM_WR for SW.
- MEM_RD: `mem_read`=1, `i_or_d`=1. Stay until `mem_ready`, then MEM_WB.
- MEM_WB: `reg_dst`=0, `mem_to_reg`=1, `reg_write`=1, `instr_done`=1; then FETCH.
- MEM_WR: `mem_write`=1, `i_or_d`=1. Stay until `mem_ready`. `instr_done` equals `mem_ready`; then FETCH.
- All outputs not listed for a state are 0.
- `mem_read` and `mem_write` are never high together.
- `mem_ready` is ignored outside FETCH, MEM_RD and MEM_WR.

## Timing
- Reset:
  - In any cycle with `reset`=1, every output is 0 and `state` shows FETCH. This includes the Mealy-gated strobes.
  - The next state after a reset cycle is FETCH.
  - Reset mid-instruction aborts it; no strobe fires in the reset cycle.
- Cycle counts with zero wait states: R 4, I-type 4, BEQ 3, LW 5, SW 4, illegal 2. Each `mem_ready`=0 cycle in a memory state adds exactly one cycle.
- `op` is sampled only in DECODE, MEM_ADDR, EXEC_I and I_WB. IR is stable there because `ir_write` fires only in FETCH.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants;
  - state encoding;
  - ALUOp codes;
  - `alu_src_b` codes.
- One natural sub-module, `multicycle_ctrl_decode`: a purely combinational map of (state, op, mem_ready, reset) to outputs. The top level keeps only the state register and next-state logic.

## Test plan
- Reset held 3 cycles mid-LW (in MEM_RD, `mem_ready`=1) → all outputs 0 during reset, no `reg_write`; after release `state`=0 and `mem_read`=1.
- ADD (`op`=0x00), `mem_ready` tied 1 → states 0,1,6,7; `reg_write`=1 only in cycle 4 with `reg_dst`=1; `instr_done` on cycle 4.
- LW (`op`=0x23), `mem_ready` low for 2 cycles in MEM_RD → 7 cycles total; `mem_to_reg`=1 and `reg_write`=1 in the last cycle; `alu_op`=101 in MEM_ADDR.
- SW (`op`=0x2B), FETCH wait 1 cycle → `pc_write` and `ir_write` only in the `mem_ready` cycle; `mem_write`=1 and `i_or_d`=1 in MEM_WR; 5 cycles total.
- BEQ (`op`=0x04) → 3 cycles; `pc_write_cond`=1, `pc_source`=1, `alu_op`=100 in cycle 3.
- `op`=0x3F → `illegal_op` pulse in DECODE, no write strobes, back to FETCH after 2 cycles; then ORI (`op`=0x0D) → `alu_op`=001 in EXEC_I and I_WB.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the multi-cycle MIPS control path.
//   - opcode constants for the supported eight-opcode subset
//   - controller state encoding (4-bit)
//   - ALUOp codes (shared with the single-cycle ALU control)
//   - alu_src_b select codes
//   - ctrl_t bundle of all control strobes/selects
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    EXEC_I   = 4'd9,
    I_WB     = 4'd10
  } state_e;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_OR    = 3'b001;
  localparam logic [2:0] ALUOP_LUI   = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_SUB   = 3'b100;
  localparam logic [2:0] ALUOP_LW    = 3'b101;
  localparam logic [2:0] ALUOP_SW    = 3'b110;
  localparam logic [2:0] ALUOP_RTYPE = 3'b111;

  localparam logic [1:0] SRCB_B        = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_IMM      = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       irWrite;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       iOrD;
    logic       regDst;
    logic       memToReg;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       pcSource;
    logic [2:0] aluOp;
    logic       instrDone;
    logic       illegalOp;
  } ctrl_t;

  function automatic logic isImmOp(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ORI) || (op == OP_LUI) || (op == OP_ANDI);
  endfunction

  function automatic logic [2:0] immAluOp(input logic [5:0] op);
    logic [2:0] code;
    case (op)
      OP_ORI:  code = ALUOP_OR;
      OP_LUI:  code = ALUOP_LUI;
      OP_ANDI: code = ALUOP_AND;
      default: code = ALUOP_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// multicycle_ctrl_decode: combinational map of (state, op, mem_ready, reset)
// to the datapath control bundle.
// Ports:
//   state    in  4  current state code (codes 11-15 decode to all-zero)
//   op       in  6  opcode from IR
//   memReady in  1  memory completes the current access
//   reset    in  1  forces every output low, including Mealy-gated strobes
//   ctrl     out    control bundle (ctrl_t)
import mips_pkg::*;

module multicycle_ctrl_decode (
  input  logic [3:0] state,
  input  logic [5:0] op,
  input  logic       memReady,
  input  logic       reset,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    if (!reset) begin
      case (state)
        FETCH: begin
          ctrl.memRead = 1'b1;
          ctrl.aluSrcB = SRCB_FOUR;
          ctrl.aluOp   = ALUOP_ADD;
          // PC+4 and IR are only captured in the cycle the fetch completes.
          ctrl.pcWrite = memReady;
          ctrl.irWrite = memReady;
        end
        DECODE: begin
          // Branch target precomputed into ALUOut.
          ctrl.aluSrcB = SRCB_IMM_SHL2;
          ctrl.aluOp   = ALUOP_ADD;
          if (!(op == OP_RTYPE || op == OP_BEQ || op == OP_LW ||
                op == OP_SW || isImmOp(op))) begin
            ctrl.illegalOp = 1'b1;
            ctrl.instrDone = 1'b1;
          end
        end
        MEM_ADDR: begin
          ctrl.aluSrcA = 1'b1;
          ctrl.aluSrcB = SRCB_IMM;
          ctrl.aluOp   = (op == OP_SW) ? ALUOP_SW : ALUOP_LW;
        end
        MEM_RD: begin
          ctrl.memRead = 1'b1;
          ctrl.iOrD    = 1'b1;
        end
        MEM_WB: begin
          ctrl.memToReg  = 1'b1;
          ctrl.regWrite  = 1'b1;
          ctrl.instrDone = 1'b1;
        end
        MEM_WR: begin
          ctrl.memWrite  = 1'b1;
          ctrl.iOrD      = 1'b1;
          ctrl.instrDone = memReady;
        end
        EXEC_R: begin
          ctrl.aluSrcA = 1'b1;
          ctrl.aluSrcB = SRCB_B;
          ctrl.aluOp   = ALUOP_RTYPE;
        end
        R_WB: begin
          ctrl.regDst    = 1'b1;
          ctrl.regWrite  = 1'b1;
          ctrl.instrDone = 1'b1;
        end
        BRANCH: begin
          ctrl.aluSrcA     = 1'b1;
          ctrl.aluSrcB     = SRCB_B;
          ctrl.aluOp       = ALUOP_SUB;
          ctrl.pcWriteCond = 1'b1;
          ctrl.pcSource    = 1'b1;
          ctrl.instrDone   = 1'b1;
        end
        EXEC_I: begin
          ctrl.aluSrcA = 1'b1;
          ctrl.aluSrcB = SRCB_IMM;
          ctrl.aluOp   = immAluOp(op);
        end
        I_WB: begin
          // ALUOp held so LUI/logic results stay stable through write-back.
          ctrl.regWrite  = 1'b1;
          ctrl.aluOp     = immAluOp(op);
          ctrl.instrDone = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: state sequencer for the shared-memory multi-cycle
// MIPS datapath. Holds the state register and next-state logic; outputs
// come from multicycle_ctrl_decode.
// Ports:
//   clk, reset (sync, active-high), op[5:0], mem_ready
//   pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write,
//   i_or_d, reg_dst, mem_to_reg, alu_src_a, alu_src_b[1:0], pc_source,
//   alu_op[ALUOP_W-1:0], instr_done, illegal_op, state[3:0] (debug)
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE   | read regs, ALUOut <= branch target, dispatch on op
// MEM_ADDR | ALUOut <= A + imm for LW/SW
// MEM_RD   | load data read, wait for mem_ready
// MEM_WB   | rt <= MDR
// MEM_WR   | store data write, wait for mem_ready
// EXEC_R   | ALUOut <= A funct B
// R_WB     | rd <= ALUOut
// BRANCH   | compare A,B; PC <= ALUOut if zero
// EXEC_I   | ALUOut <= A op imm
// I_WB     | rt <= ALUOut
import mips_pkg::*;

module multicycle_control #(
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               ir_write,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               i_or_d,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               pc_source,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [3:0]         state
);

  logic [3:0] stateQ;
  ctrl_t      ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= FETCH;
    end else begin
      case (stateQ)
        FETCH:    if (mem_ready) stateQ <= DECODE;
        DECODE: begin
          if (op == OP_RTYPE)                   stateQ <= EXEC_R;
          else if (isImmOp(op))                 stateQ <= EXEC_I;
          else if (op == OP_BEQ)                stateQ <= BRANCH;
          else if (op == OP_LW || op == OP_SW)  stateQ <= MEM_ADDR;
          else                                  stateQ <= FETCH;
        end
        MEM_ADDR: stateQ <= (op == OP_SW) ? MEM_WR : MEM_RD;
        MEM_RD:   if (mem_ready) stateQ <= MEM_WB;
        MEM_WR:   if (mem_ready) stateQ <= FETCH;
        EXEC_R:   stateQ <= R_WB;
        EXEC_I:   stateQ <= I_WB;
        default:  stateQ <= FETCH;
      endcase
    end
  end

  multicycle_ctrl_decode uDecode (
    .state    (stateQ),
    .op       (op),
    .memReady (mem_ready),
    .reset    (reset),
    .ctrl     (ctrl)
  );

  assign pc_write      = ctrl.pcWrite;
  assign pc_write_cond = ctrl.pcWriteCond;
  assign ir_write      = ctrl.irWrite;
  assign reg_write     = ctrl.regWrite;
  assign mem_read      = ctrl.memRead;
  assign mem_write     = ctrl.memWrite;
  assign i_or_d        = ctrl.iOrD;
  assign reg_dst       = ctrl.regDst;
  assign mem_to_reg    = ctrl.memToReg;
  assign alu_src_a     = ctrl.aluSrcA;
  assign alu_src_b     = ctrl.aluSrcB;
  assign pc_source     = ctrl.pcSource;
  assign alu_op        = ALUOP_W'(ctrl.aluOp);
  assign instr_done    = ctrl.instrDone;
  assign illegal_op    = ctrl.illegalOp;
  // During a reset cycle the register still holds the aborted state.
  assign state         = reset ? 4'(FETCH) : stateQ;

endmodule
